ddr_wr_burst_ctrl: RTL and testbench

Drains the 256-bit read side of the DDR write FIFO into fixed-length AXI-style write bursts to DDR. It watches the FIFO read water level and starts a burst only when a full burst is buffered. It then issues the address, streams the beats with a 2-entry skid buffer, and waits for the write response. It sits between write_ddr_fifo (read port) and the DDR controller write channel, and walks a circular frame region in DDR.

---
 rtl/ddr_wr_burst_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_ddr_wr_burst_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_wr_burst_ctrl.sv
// Write-FIFO drain into fixed-length DDR write bursts.
// Walks a circular frame region; 2-entry skid buffer on the W channel.
module ddr_wr_burst_ctrl #(
    parameter int                  DATA_WIDTH     = 256,
    parameter int                  LEVEL_WIDTH    = 9,
    parameter int                  ADDR_WIDTH     = 28,
    parameter int                  BURST_LEN      = 16,
    parameter int                  BYTES_PER_BEAT = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
    parameter int                  FRAME_BEATS    = 4096
) (
    input  logic                   clk,
    input  logic                   tb_rst,
    input  logic                   enable,
    input  logic                   frame_start,
    output logic                   fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]  fifo_rd_data,
    input  logic [LEVEL_WIDTH-1:0] fifo_rd_water_level,
    input  logic                   fifo_rd_empty,
    output logic                   ddr_awvalid,
    input  logic                   ddr_awready,
    output logic [ADDR_WIDTH-1:0]  ddr_awaddr,
    output logic [7:0]             ddr_awlen,
    output logic                   ddr_wvalid,
    input  logic                   ddr_wready,
    output logic [DATA_WIDTH-1:0]  ddr_wdata,
    output logic                   ddr_wlast,
    input  logic                   ddr_bvalid,
    input  logic [1:0]             ddr_bresp,
    output logic                   ddr_bready,
    output logic                   busy,
    output logic                   burst_done,
    output logic                   frame_done,
    output logic                   resp_err
);

    localparam int CW  = 9;
    localparam int FBW = $clog2(FRAME_BEATS + 1);
    localparam logic [ADDR_WIDTH-1:0] STRIDE =
        ADDR_WIDTH'(BURST_LEN * BYTES_PER_BEAT);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic                    awvalid_q, awvalid_d;
    logic                    bready_q, bready_d;
    logic                    burst_done_q, burst_done_d;
    logic                    frame_done_q, frame_done_d;
    logic                    resp_err_q, resp_err_d;
    logic                    pend_q, pend_d;
    logic [FBW-1:0]          fbeats_q, fbeats_d;
    logic [CW-1:0]           fetched_q, fetched_d;
    logic [CW-1:0]           sent_q, sent_d;
    logic [DATA_WIDTH-1:0]   skid0_q, skid0_d;
    logic [DATA_WIDTH-1:0]   skid1_q, skid1_d;
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              cnt_q, cnt_d;
    logic                    infl_q, infl_d;

    logic                    start;
    logic                    w_hs;
    logic                    last_beat;
    logic                    rd_en;
    logic [2:0]              occ;
    logic [FBW:0]            fb_next;
    logic                    wrap;

    assign start = enable &&
        ({1'b0, fifo_rd_water_level} >= (LEVEL_WIDTH+1)'(BURST_LEN));
    assign last_beat = (sent_q == CW'(BURST_LEN - 1));
    assign w_hs      = (cnt_q != 2'd0) && ddr_wready;

    // Credit this cycle's pop so a steady wready stream has no bubbles.
    assign occ = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, w_hs};
    assign rd_en = (state_q == DATA) && (fetched_q < CW'(BURST_LEN)) &&
                   (occ < 3'd2) && !fifo_rd_empty;

    assign fb_next = {1'b0, fbeats_q} + (FBW+1)'(BURST_LEN);
    assign wrap    = (fb_next >= (FBW+1)'(FRAME_BEATS));

    always_comb begin
        state_d      = state_q;
        awaddr_d     = awaddr_q;
        awvalid_d    = awvalid_q;
        bready_d     = bready_q;
        burst_done_d = 1'b0;
        frame_done_d = 1'b0;
        resp_err_d   = resp_err_q;
        pend_d       = pend_q;
        fbeats_d     = fbeats_q;
        fetched_d    = fetched_q + CW'(rd_en);
        sent_d       = sent_q + CW'(w_hs);
        skid0_d      = skid0_q;
        skid1_d      = skid1_q;
        wr_ptr_d     = wr_ptr_q ^ infl_q;
        rd_ptr_d     = rd_ptr_q ^ w_hs;
        cnt_d        = cnt_q + {1'b0, infl_q} - {1'b0, w_hs};
        infl_d       = rd_en;

        if (infl_q && !wr_ptr_q) skid0_d = fifo_rd_data;
        if (infl_q && wr_ptr_q)  skid1_d = fifo_rd_data;

        if (frame_start && state_q != IDLE) pend_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (frame_start) begin
                    awaddr_d = BASE_ADDR;
                    fbeats_d = '0;
                end
                if (start) begin
                    state_d   = ADDR;
                    awvalid_d = 1'b1;
                end
            end
            ADDR: begin
                if (ddr_awready) begin
                    state_d   = DATA;
                    awvalid_d = 1'b0;
                    fetched_d = '0;
                    sent_d    = '0;
                end
            end
            DATA: begin
                if (w_hs && last_beat) begin
                    state_d  = RESP;
                    bready_d = 1'b1;
                end
            end
            RESP: begin
                if (ddr_bvalid) begin
                    state_d      = IDLE;
                    bready_d     = 1'b0;
                    burst_done_d = 1'b1;
                    pend_d       = 1'b0;
                    if (ddr_bresp != 2'b00) resp_err_d = 1'b1;
                    if (wrap) begin
                        awaddr_d     = BASE_ADDR;
                        fbeats_d     = '0;
                        frame_done_d = 1'b1;
                    end else if (pend_q || frame_start) begin
                        awaddr_d = BASE_ADDR;
                        fbeats_d = '0;
                    end else begin
                        awaddr_d = awaddr_q + STRIDE;
                        fbeats_d = fb_next[FBW-1:0];
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            state_q      <= IDLE;
            awaddr_q     <= BASE_ADDR;
            awvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            burst_done_q <= 1'b0;
            frame_done_q <= 1'b0;
            resp_err_q   <= 1'b0;
            pend_q       <= 1'b0;
            fbeats_q     <= '0;
            fetched_q    <= '0;
            sent_q       <= '0;
            skid0_q      <= '0;
            skid1_q      <= '0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            cnt_q        <= '0;
            infl_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            awaddr_q     <= awaddr_d;
            awvalid_q    <= awvalid_d;
            bready_q     <= bready_d;
            burst_done_q <= burst_done_d;
            frame_done_q <= frame_done_d;
            resp_err_q   <= resp_err_d;
            pend_q       <= pend_d;
            fbeats_q     <= fbeats_d;
            fetched_q    <= fetched_d;
            sent_q       <= sent_d;
            skid0_q      <= skid0_d;
            skid1_q      <= skid1_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            infl_q       <= infl_d;
        end
    end

    assign fifo_rd_en  = rd_en;
    assign ddr_awvalid = awvalid_q;
    assign ddr_awaddr  = awaddr_q;
    assign ddr_awlen   = 8'(BURST_LEN - 1);
    assign ddr_wvalid  = (cnt_q != 2'd0);
    assign ddr_wdata   = rd_ptr_q ? skid1_q : skid0_q;
    assign ddr_wlast   = (cnt_q != 2'd0) && last_beat;
    assign ddr_bready  = bready_q;
    assign busy        = (state_q != IDLE);
    assign burst_done  = burst_done_q;
    assign frame_done  = frame_done_q;
    assign resp_err    = resp_err_q;

endmodule

// File: tb/tb_ddr_wr_burst_ctrl.sv
// Bench for ddr_wr_burst_ctrl: FIFO model, scoreboard queues for
// expected W data and AW addresses, handshake monitor at negedge.
module tb_ddr_wr_burst_ctrl;

    localparam int DW = 256;
    localparam int LW = 9;
    localparam int AW = 28;
    localparam int BL = 16;
    localparam int FB = 32;

    logic          clk = 1'b0;
    logic          tb_rst;
    logic          enable;
    logic          frame_start;
    logic          fifo_rd_en;
    logic [DW-1:0] fifo_rd_data;
    logic [LW-1:0] fifo_rd_water_level;
    logic          fifo_rd_empty;
    logic          ddr_awvalid;
    logic          ddr_awready;
    logic [AW-1:0] ddr_awaddr;
    logic [7:0]    ddr_awlen;
    logic          ddr_wvalid;
    logic          ddr_wready;
    logic [DW-1:0] ddr_wdata;
    logic          ddr_wlast;
    logic          ddr_bvalid;
    logic [1:0]    ddr_bresp;
    logic          ddr_bready;
    logic          busy;
    logic          burst_done;
    logic          frame_done;
    logic          resp_err;

    ddr_wr_burst_ctrl #(
        .FRAME_BEATS(FB)
    ) dut (
        .clk                 (clk),
        .tb_rst              (tb_rst),
        .enable              (enable),
        .frame_start         (frame_start),
        .fifo_rd_en          (fifo_rd_en),
        .fifo_rd_data        (fifo_rd_data),
        .fifo_rd_water_level (fifo_rd_water_level),
        .fifo_rd_empty       (fifo_rd_empty),
        .ddr_awvalid         (ddr_awvalid),
        .ddr_awready         (ddr_awready),
        .ddr_awaddr          (ddr_awaddr),
        .ddr_awlen           (ddr_awlen),
        .ddr_wvalid          (ddr_wvalid),
        .ddr_wready          (ddr_wready),
        .ddr_wdata           (ddr_wdata),
        .ddr_wlast           (ddr_wlast),
        .ddr_bvalid          (ddr_bvalid),
        .ddr_bresp           (ddr_bresp),
        .ddr_bready          (ddr_bready),
        .busy                (busy),
        .burst_done          (burst_done),
        .frame_done          (frame_done),
        .resp_err            (resp_err)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] exp_d[$];
    logic [AW-1:0] exp_aw[$];

    int            n_chk, n_err;
    int            bd_cnt, fd_cnt, aw_cnt, hs_cnt, beat_idx, occ_m;
    logic          infl_m, rd_s, prev_stall, prev_last;
    logic [DW-1:0] prev_data;

    task automatic chk(input string tag, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic refresh();
        fifo_rd_water_level = LW'(fifo_q.size());
        fifo_rd_empty       = (fifo_q.size() == 0);
    endtask

    task automatic monitor();
        logic hs;
        hs = ddr_wvalid && ddr_wready;
        if (prev_stall) begin
            chk("w_hold_valid", ddr_wvalid, 1);
            chk("w_hold_data", ddr_wdata, prev_data);
            chk("w_hold_last", ddr_wlast, prev_last);
        end
        if (ddr_awvalid && ddr_awready) begin
            aw_cnt++;
            if (exp_aw.size() == 0) chk("aw_unexpected", 1, 0);
            else chk("awaddr", ddr_awaddr, exp_aw.pop_front());
            chk("awlen", ddr_awlen, BL - 1);
        end
        if (hs) begin
            hs_cnt++;
            if (exp_d.size() == 0) chk("w_unexpected", 1, 0);
            else chk("wdata", ddr_wdata, exp_d.pop_front());
            chk("wlast", ddr_wlast, beat_idx == BL - 1);
            beat_idx = (beat_idx == BL - 1) ? 0 : beat_idx + 1;
        end
        if (fifo_rd_en)
            chk("skid_room", (occ_m + int'(infl_m) - int'(hs)) < 2, 1);
        occ_m  = occ_m + int'(infl_m) - int'(hs);
        infl_m = fifo_rd_en;
        rd_s   = fifo_rd_en;
        if (burst_done) bd_cnt++;
        if (frame_done) begin
            fd_cnt++;
            chk("fd_with_bd", burst_done, 1);
        end
        prev_stall = ddr_wvalid && !ddr_wready;
        prev_data  = ddr_wdata;
        prev_last  = ddr_wlast;
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (rd_s) begin
            if (fifo_q.size() == 0) chk("fifo_underflow", 1, 0);
            else fifo_rd_data = fifo_q.pop_front();
        end
        refresh();
    endtask

    task automatic push_word();
        logic [DW-1:0] w;
        for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom;
        fifo_q.push_back(w);
        exp_d.push_back(w);
        refresh();
    endtask

    task automatic push_words(input int n);
        repeat (n) begin
            push_word();
            step();
        end
    endtask

    task automatic wait_bd(input int target, input int budget,
                           input bit toggle);
        for (int i = 0; i < budget && bd_cnt < target; i++) begin
            if (toggle) ddr_wready = ~ddr_wready;
            step();
        end
        chk("bursts_done", bd_cnt, target);
        ddr_wready = 1'b1;
    endtask

    task automatic check_reset_vals(input string p);
        chk({p, "_awvalid"}, ddr_awvalid, 0);
        chk({p, "_awaddr"}, ddr_awaddr, 0);
        chk({p, "_awlen"}, ddr_awlen, BL - 1);
        chk({p, "_wvalid"}, ddr_wvalid, 0);
        chk({p, "_wlast"}, ddr_wlast, 0);
        chk({p, "_wdata"}, ddr_wdata, 0);
        chk({p, "_rd_en"}, fifo_rd_en, 0);
        chk({p, "_bready"}, ddr_bready, 0);
        chk({p, "_busy"}, busy, 0);
        chk({p, "_bdone"}, burst_done, 0);
        chk({p, "_fdone"}, frame_done, 0);
        chk({p, "_resp_err"}, resp_err, 0);
    endtask

    initial begin
        int  a0, b0, f0, h0;
        bit  seen;
        n_chk = 0; n_err = 0;
        bd_cnt = 0; fd_cnt = 0; aw_cnt = 0; hs_cnt = 0;
        beat_idx = 0; occ_m = 0;
        infl_m = 0; rd_s = 0; prev_stall = 0; prev_last = 0;
        prev_data = '0;
        tb_rst = 1'b1; enable = 1'b0; frame_start = 1'b0;
        ddr_awready = 1'b1; ddr_wready = 1'b1;
        ddr_bvalid = 1'b1; ddr_bresp = 2'b00;
        fifo_rd_data = '0;
        refresh();
        repeat (3) step();
        check_reset_vals("rst");
        tb_rst = 1'b0;
        step();

        // basic burst
        enable = 1'b1;
        exp_aw.push_back(AW'('h0));
        push_words(BL);
        wait_bd(1, 60, 0);
        chk("t1_next_addr", ddr_awaddr, 'h200);

        // one word short of a burst, then the last word
        a0 = aw_cnt; f0 = fd_cnt; b0 = bd_cnt;
        push_words(BL - 1);
        repeat (20) step();
        chk("t2_no_start", aw_cnt, a0);
        chk("t2_idle", busy, 0);
        exp_aw.push_back(AW'('h200));
        push_word();
        seen = 0;
        for (int i = 0; i < 2 && !seen; i++) begin
            step();
            if (ddr_awvalid) seen = 1;
        end
        chk("t2_start_lat", seen, 1);
        wait_bd(b0 + 1, 60, 0);
        chk("t2_wrap_fd", fd_cnt, f0 + 1);
        chk("t2_wrap_addr", ddr_awaddr, 'h0);

        // wready toggling
        h0 = hs_cnt; b0 = bd_cnt;
        exp_aw.push_back(AW'('h0));
        push_words(BL);
        wait_bd(b0 + 1, 100, 1);
        chk("t3_beats", hs_cnt - h0, BL);
        chk("t3_next_addr", ddr_awaddr, 'h200);

        // frame_start while idle, then two full frames
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        step();
        chk("t4_fs_idle_addr", ddr_awaddr, 'h0);
        f0 = fd_cnt; b0 = bd_cnt;
        exp_aw.push_back(AW'('h0));
        exp_aw.push_back(AW'('h200));
        exp_aw.push_back(AW'('h0));
        exp_aw.push_back(AW'('h200));
        push_words(4 * BL);
        wait_bd(b0 + 4, 200, 0);
        chk("t4_frame_done", fd_cnt, f0 + 2);

        // error response, frame_start mid-burst
        f0 = fd_cnt; b0 = bd_cnt;
        ddr_bresp = 2'b10;
        exp_aw.push_back(AW'('h0));
        exp_aw.push_back(AW'('h0));
        exp_aw.push_back(AW'('h200));
        push_words(BL);
        for (int i = 0; i < 20 && !busy; i++) step();
        chk("t5_busy", busy, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        wait_bd(b0 + 1, 60, 0);
        ddr_bresp = 2'b00;
        chk("t5_resp_err", resp_err, 1);
        chk("t5_fs_no_fd", fd_cnt, f0);
        chk("t5_fs_addr", ddr_awaddr, 'h0);
        push_words(2 * BL);
        wait_bd(b0 + 3, 100, 0);
        chk("t5_err_sticky", resp_err, 1);
        chk("t5_wrap_fd", fd_cnt, f0 + 1);

        // reset during beat 5 of a burst at 0x200
        b0 = bd_cnt;
        exp_aw.push_back(AW'('h0));
        exp_aw.push_back(AW'('h200));
        push_words(BL);
        wait_bd(b0 + 1, 60, 0);
        push_words(BL);
        for (int i = 0; i < 60 && beat_idx != 5; i++) step();
        chk("t6_at_beat5", beat_idx, 5);
        tb_rst = 1'b1;
        #1;
        check_reset_vals("t6");
        fifo_q.delete();
        exp_d.delete();
        refresh();
        beat_idx = 0; occ_m = 0; infl_m = 0; rd_s = 0; prev_stall = 0;
        repeat (2) step();
        tb_rst = 1'b0;
        step();
        b0 = bd_cnt;
        exp_aw.push_back(AW'('h0));
        push_words(BL);
        wait_bd(b0 + 1, 60, 0);
        chk("t6_recover_addr", ddr_awaddr, 'h200);
        chk("t6_err_cleared", resp_err, 0);

        repeat (5) step();
        chk("drained_w", exp_d.size(), 0);
        chk("drained_aw", exp_aw.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
